// File: rtl/riscv_v_uop_seq_pkg.sv
// Shared types and helpers for the vector register-group micro-op sequencer.
package riscv_v_uop_seq_pkg;

    localparam int RISCV_V_NUM_VREGS = 32;
    localparam int RISCV_V_MAX_GROUP = 8;
    localparam int RISCV_V_VREG_AW   = $clog2(RISCV_V_NUM_VREGS);
    localparam int RISCV_V_IDX_W     = $clog2(RISCV_V_MAX_GROUP);

    typedef logic [RISCV_V_VREG_AW-1:0] riscv_v_vreg_t;
    typedef logic [RISCV_V_IDX_W-1:0]   riscv_v_uidx_t;
    typedef logic [RISCV_V_IDX_W:0]     riscv_v_gsize_t;

    typedef enum logic [2:0] {
        VLMUL_1   = 3'b000,
        VLMUL_2   = 3'b001,
        VLMUL_4   = 3'b010,
        VLMUL_8   = 3'b011,
        VLMUL_RSV = 3'b100,
        VLMUL_F8  = 3'b101,
        VLMUL_F4  = 3'b110,
        VLMUL_F2  = 3'b111
    } riscv_v_vlmul_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } riscv_v_seq_state_t;

    typedef struct packed {
        logic          valid;
        riscv_v_vreg_t vs1;
        riscv_v_vreg_t vs2;
        riscv_v_vreg_t vd;
        riscv_v_uidx_t idx;
        logic          first;
        logic          last;
    } riscv_v_uop_t;

    typedef struct packed {
        riscv_v_gsize_t grp;
        logic           rsv;
    } riscv_v_group_t;

    // Fractional LMUL still occupies one whole register.
    function automatic riscv_v_group_t riscv_v_lmul_group(riscv_v_vlmul_t vlmul);
        riscv_v_group_t r;
        r.grp = riscv_v_gsize_t'(1);
        r.rsv = 1'b0;
        case (vlmul)
            VLMUL_2:   r.grp = riscv_v_gsize_t'(2);
            VLMUL_4:   r.grp = riscv_v_gsize_t'(4);
            VLMUL_8:   r.grp = riscv_v_gsize_t'(8);
            VLMUL_RSV: r.rsv = 1'b1;
            default:   ;
        endcase
        return r;
    endfunction

    function automatic logic riscv_v_aligned(riscv_v_vreg_t base, riscv_v_gsize_t grp);
        riscv_v_vreg_t mask;
        mask = riscv_v_vreg_t'(grp) - riscv_v_vreg_t'(1);
        return (base & mask) == '0;
    endfunction

endpackage

// File: rtl/riscv_v_uop_seq_if.sv
// Decode-side issue handshake and EXE-side micro-op bus of the sequencer.
interface riscv_v_uop_seq_if;
    import riscv_v_uop_seq_pkg::*;

    logic           issue_valid;
    logic           issue_ready;
    riscv_v_vreg_t  issue_vs1;
    riscv_v_vreg_t  issue_vs2;
    riscv_v_vreg_t  issue_vd;
    riscv_v_vlmul_t issue_vlmul;
    logic           issue_vs1_scalar;
    logic           issue_reduct;

    logic           uop_valid;
    riscv_v_vreg_t  uop_vs1;
    riscv_v_vreg_t  uop_vs2;
    riscv_v_vreg_t  uop_vd;
    riscv_v_uidx_t  uop_idx;
    logic           uop_first;
    logic           uop_last;
    logic           seq_stall;
    logic           illegal;

    modport master (
        output issue_valid, issue_vs1, issue_vs2, issue_vd, issue_vlmul,
               issue_vs1_scalar, issue_reduct,
        input  issue_ready, uop_valid, uop_vs1, uop_vs2, uop_vd, uop_idx,
               uop_first, uop_last, seq_stall, illegal
    );

    modport slave (
        input  issue_valid, issue_vs1, issue_vs2, issue_vd, issue_vlmul,
               issue_vs1_scalar, issue_reduct,
        output issue_ready, uop_valid, uop_vs1, uop_vs2, uop_vd, uop_idx,
               uop_first, uop_last, seq_stall, illegal
    );

endinterface

// File: rtl/riscv_v_uop_seq.sv
// Splits one LMUL>1 vector instruction into per-register micro-ops, one per cycle,
// and holds the front end while a group is still being emitted.
module riscv_v_uop_seq
    import riscv_v_uop_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               riscv_stall,
    riscv_v_uop_seq_if.slave   bus
);

    riscv_v_seq_state_t state_q, state_d;
    riscv_v_uop_t       uop_q, uop_d;
    riscv_v_uidx_t      glast_q, glast_d;
    riscv_v_vreg_t      bvd_q, bvd_d, bvs2_q, bvs2_d, bvs1_q, bvs1_d;
    logic               fix_vd_q, fix_vd_d, fix_vs1_q, fix_vs1_d;
    logic               seq_stall_q, seq_stall_d;
    logic               illegal_q, illegal_d;

    riscv_v_group_t     grp;
    logic               bad, ready, accept;
    riscv_v_uidx_t      nidx;

    assign grp = riscv_v_lmul_group(bus.issue_vlmul);
    assign bad = grp.rsv
               | ~riscv_v_aligned(bus.issue_vd, grp.grp)
               | ~riscv_v_aligned(bus.issue_vs2, grp.grp)
               | (~bus.issue_vs1_scalar & ~riscv_v_aligned(bus.issue_vs1, grp.grp));

    // A new group may be taken while the final uop of the current one issues.
    assign ready  = ~riscv_stall & ~flush &
                    ((state_q == SEQ_IDLE) | ((state_q == SEQ_RUN) & uop_q.last));
    assign accept = bus.issue_valid & ready;
    assign nidx   = uop_q.idx + riscv_v_uidx_t'(1);

    always_comb begin
        state_d   = state_q;
        uop_d     = uop_q;
        glast_d   = glast_q;
        bvd_d     = bvd_q;
        bvs2_d    = bvs2_q;
        bvs1_d    = bvs1_q;
        fix_vd_d  = fix_vd_q;
        fix_vs1_d = fix_vs1_q;
        illegal_d = 1'b0;

        if (flush) begin
            state_d     = SEQ_IDLE;
            uop_d.valid = 1'b0;
            uop_d.first = 1'b0;
            uop_d.last  = 1'b0;
        end else if (!riscv_stall) begin
            if (accept && bad) begin
                illegal_d   = 1'b1;
                state_d     = SEQ_IDLE;
                uop_d.valid = 1'b0;
                uop_d.first = 1'b0;
                uop_d.last  = 1'b0;
            end else if (accept) begin
                state_d     = SEQ_RUN;
                glast_d     = riscv_v_uidx_t'(grp.grp - riscv_v_gsize_t'(1));
                bvd_d       = bus.issue_vd;
                bvs2_d      = bus.issue_vs2;
                bvs1_d      = bus.issue_vs1;
                fix_vd_d    = bus.issue_reduct;
                fix_vs1_d   = bus.issue_reduct | bus.issue_vs1_scalar;
                uop_d.valid = 1'b1;
                uop_d.vd    = bus.issue_vd;
                uop_d.vs2   = bus.issue_vs2;
                uop_d.vs1   = bus.issue_vs1;
                uop_d.idx   = '0;
                uop_d.first = 1'b1;
                uop_d.last  = (grp.grp == riscv_v_gsize_t'(1));
            end else if (state_q == SEQ_RUN) begin
                if (uop_q.last) begin
                    state_d     = SEQ_IDLE;
                    uop_d.valid = 1'b0;
                    uop_d.first = 1'b0;
                    uop_d.last  = 1'b0;
                end else begin
                    uop_d.idx   = nidx;
                    uop_d.vd    = fix_vd_q  ? bvd_q  : bvd_q  + riscv_v_vreg_t'(nidx);
                    uop_d.vs2   = bvs2_q + riscv_v_vreg_t'(nidx);
                    uop_d.vs1   = fix_vs1_q ? bvs1_q : bvs1_q + riscv_v_vreg_t'(nidx);
                    uop_d.first = 1'b0;
                    uop_d.last  = (nidx == glast_q);
                end
            end
        end

        seq_stall_d = (state_d == SEQ_RUN) & uop_d.valid & ~uop_d.last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEQ_IDLE;
            uop_q       <= '0;
            glast_q     <= '0;
            bvd_q       <= '0;
            bvs2_q      <= '0;
            bvs1_q      <= '0;
            fix_vd_q    <= 1'b0;
            fix_vs1_q   <= 1'b0;
            seq_stall_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            uop_q       <= uop_d;
            glast_q     <= glast_d;
            bvd_q       <= bvd_d;
            bvs2_q      <= bvs2_d;
            bvs1_q      <= bvs1_d;
            fix_vd_q    <= fix_vd_d;
            fix_vs1_q   <= fix_vs1_d;
            seq_stall_q <= seq_stall_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.issue_ready = ready;
    assign bus.uop_valid   = uop_q.valid;
    assign bus.uop_vs1     = uop_q.vs1;
    assign bus.uop_vs2     = uop_q.vs2;
    assign bus.uop_vd      = uop_q.vd;
    assign bus.uop_idx     = uop_q.idx;
    assign bus.uop_first   = uop_q.first;
    assign bus.uop_last    = uop_q.last;
    assign bus.seq_stall   = seq_stall_q;
    assign bus.illegal     = illegal_q;

endmodule
